// File: rtl/m_muldiv.sv
// Iterative RV32M multiply/divide unit: 32 radix-2 steps, one fix-up cycle,
// then a single-cycle register-file write. Fixed 34-cycle latency per operation.
module m_muldiv (
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_start,
    input  logic [2:0]  w_funct3,
    input  logic [31:0] w_rs1,
    input  logic [31:0] w_rs2,
    input  logic [4:0]  w_rd,
    output logic        w_busy,
    output logic        w_done,
    output logic        w_we,
    output logic [4:0]  w_wa,
    output logic [31:0] w_wd
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned STEPS = 32;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [2:0]        op;
    logic [4:0]        rd_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   opa;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;
    logic              div_ovf;

    // Operand conditioning at acceptance
    logic              s1_signed, s2_signed, sign1, sign2;
    logic [XLEN-1:0]   mag1, mag2;

    always_comb begin
        s1_signed = (w_funct3 == 3'b001) || (w_funct3 == 3'b010) ||
                    (w_funct3[2] && !w_funct3[0]);
        s2_signed = (w_funct3 == 3'b001) || (w_funct3[2] && !w_funct3[0]);
        sign1     = s1_signed && w_rs1[XLEN-1];
        sign2     = s2_signed && w_rs2[XLEN-1];
        mag1      = sign1 ? XLEN'(-w_rs1) : w_rs1;
        mag2      = sign2 ? XLEN'(-w_rs2) : w_rs2;
    end

    // One shift-add (multiply) or restoring shift-subtract (divide) step
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;

    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opa} : (XLEN+1)'(0));
        div_shift = {hi, lo[XLEN-1]};
        div_diff  = div_shift - {1'b0, opa};
    end

    // Sign correction and special-case substitution
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   q_fix, r_fix, result;

    always_comb begin
        prod_fix = neg_q ? (2*XLEN)'(-{hi, lo}) : {hi, lo};
        q_fix    = neg_q ? XLEN'(-lo) : lo;
        r_fix    = neg_r ? XLEN'(-hi) : hi;
        result   = '0;
        case (op)
            3'b000:                 result = prod_fix[XLEN-1:0];
            3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
            3'b100, 3'b101: begin
                if (div_zero)     result = {XLEN{1'b1}};
                else if (div_ovf) result = {1'b1, {(XLEN-1){1'b0}}};
                else              result = q_fix;
            end
            default: begin
                if (div_zero)     result = rs1_q;
                else if (div_ovf) result = '0;
                else              result = r_fix;
            end
        endcase
    end

    // Control FSM and datapath registers
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op       <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            opa      <= '0;
            hi       <= '0;
            lo       <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            div_ovf  <= 1'b0;
            w_busy   <= 1'b0;
            w_done   <= 1'b0;
            w_we     <= 1'b0;
            w_wa     <= '0;
            w_wd     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (w_start) begin
                        state    <= S_CALC;
                        cnt      <= '0;
                        op       <= w_funct3;
                        rd_q     <= w_rd;
                        rs1_q    <= w_rs1;
                        hi       <= '0;
                        opa      <= w_funct3[2] ? mag2 : mag1;
                        lo       <= w_funct3[2] ? mag1 : mag2;
                        neg_q    <= sign1 ^ sign2;
                        neg_r    <= sign1;
                        div_zero <= (w_rs2 == '0);
                        div_ovf  <= !w_funct3[0] &&
                                    (w_rs1 == {1'b1, {(XLEN-1){1'b0}}}) &&
                                    (w_rs2 == {XLEN{1'b1}});
                        w_busy   <= 1'b1;
                    end
                end
                S_CALC: begin
                    if (!op[2]) begin
                        hi <= mul_sum[XLEN:1];
                        lo <= {mul_sum[0], lo[XLEN-1:1]};
                    end else if (!div_diff[XLEN]) begin
                        hi <= div_diff[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], 1'b1};
                    end else begin
                        hi <= div_shift[XLEN-1:0];
                        lo <= {lo[XLEN-2:0], 1'b0};
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state  <= S_DONE;
                    w_done <= 1'b1;
                    w_we   <= (rd_q != '0);
                    w_wa   <= rd_q;
                    w_wd   <= result;
                end
                default: begin
                    state  <= S_IDLE;
                    w_done <= 1'b0;
                    w_we   <= 1'b0;
                    w_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m_muldiv.sv
// Directed and randomized self-checking bench for the RV32M multiply/divide unit.
module tb_m_muldiv;

    logic        w_clk = 1'b0;
    logic        w_rst_n = 1'b0;
    logic        w_start = 1'b0;
    logic [2:0]  w_funct3 = '0;
    logic [31:0] w_rs1 = '0;
    logic [31:0] w_rs2 = '0;
    logic [4:0]  w_rd = '0;
    logic        w_busy, w_done, w_we;
    logic [4:0]  w_wa;
    logic [31:0] w_wd;

    int total = 0;
    int bad = 0;

    m_muldiv dut (
        .w_clk(w_clk), .w_rst_n(w_rst_n), .w_start(w_start), .w_funct3(w_funct3),
        .w_rs1(w_rs1), .w_rs2(w_rs2), .w_rd(w_rd), .w_busy(w_busy),
        .w_done(w_done), .w_we(w_we), .w_wa(w_wa), .w_wd(w_wd)
    );

    always #5 w_clk = ~w_clk;

    // Independent reference built on 64-bit arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] x, y, p;
        case (f)
            3'b000: begin x = {32'd0, a}; y = {32'd0, b}; p = x * y; return p[31:0]; end
            3'b001: begin x = {{32{a[31]}}, a}; y = {{32{b[31]}}, b}; p = x * y; return p[63:32]; end
            3'b010: begin x = {{32{a[31]}}, a}; y = {32'd0, b}; p = x * y; return p[63:32]; end
            3'b011: begin x = {32'd0, a}; y = {32'd0, b}; p = x * y; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFFFFFF;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h80000000;
                return $signed(a) / $signed(b);
            end
            3'b101: return (b == 0) ? 32'hFFFFFFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return 32'h0;
                return $signed(a) % $signed(b);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Issue one op (start set after an edge, accepted at E0), observe 34 edges after E0
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int pulse_at,
                         output logic [31:0] wd, output logic [4:0] wa, output int done_at,
                         output int n_done, output int n_we, output logic busy_mid,
                         output logic busy_end);
        w_funct3 = f; w_rs1 = a; w_rs2 = b; w_rd = rd; w_start = 1'b1;
        @(posedge w_clk); #1;
        w_start = 1'b0;
        w_funct3 = 3'($urandom); w_rs1 = $urandom; w_rs2 = $urandom; w_rd = 5'd31;
        wd = '0; wa = '0; done_at = -1; n_done = 0; n_we = 0; busy_mid = 1'b0; busy_end = 1'b1;
        for (int i = 1; i <= 34; i++) begin
            w_start = (i == pulse_at);
            @(posedge w_clk); #1;
            w_start = 1'b0;
            if (w_done) begin
                n_done++;
                if (done_at < 0) begin done_at = i; wd = w_wd; wa = w_wa; end
            end
            if (w_we) n_we++;
            if (i == 33) busy_mid = w_busy;
            if (i == 34) busy_end = w_busy;
        end
    endtask

    task automatic test_reset();
        w_rst_n = 1'b0;
        repeat (2) @(posedge w_clk);
        #1;
        total++;
        if ({w_busy, w_done, w_we, w_wa, w_wd} !== 40'd0) begin
            bad++; $display("FAIL reset_outputs: got busy=%b done=%b we=%b wa=%0d wd=%h, need all 0",
                            w_busy, w_done, w_we, w_wa, w_wd);
        end
        w_rst_n = 1'b1;
        @(posedge w_clk); #1;
    endtask

    task automatic test_mul();
        logic [31:0] wd; logic [4:0] wa; int da, nd, nw; logic bm, be;
        do_op(3'b000, 32'd7, 32'hFFFFFFFD, 5'd5, -1, wd, wa, da, nd, nw, bm, be);
        total++;
        if (wd !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_wd: got %h need FFFFFFEB", wd); end
        total++;
        if (wa !== 5'd5) begin bad++; $display("FAIL mul_wa: got %0d need 5", wa); end
        total++;
        if (da !== 33 || nd !== 1 || nw !== 1) begin
            bad++; $display("FAIL mul_timing: done_at=%0d n_done=%0d n_we=%0d need 33/1/1", da, nd, nw);
        end
        total++;
        if (bm !== 1'b1 || be !== 1'b0) begin
            bad++; $display("FAIL mul_busy: busy@E33=%b busy@E34=%b need 1/0", bm, be);
        end
        repeat (3) @(posedge w_clk);
        #1;
        total++;
        if (w_wd !== 32'hFFFFFFEB || w_wa !== 5'd5) begin
            bad++; $display("FAIL mul_hold: got wa=%0d wd=%h need 5/FFFFFFEB", w_wa, w_wd);
        end
    endtask

    task automatic test_mulh();
        logic [2:0]  fs [3] = '{3'b001, 3'b010, 3'b011};
        logic [31:0] ex [3] = '{32'h00000000, 32'h80000000, 32'h7FFFFFFF};
        logic [31:0] wd; logic [4:0] wa; int da, nd, nw; logic bm, be;
        for (int k = 0; k < 3; k++) begin
            do_op(fs[k], 32'h80000000, 32'hFFFFFFFF, 5'd7, -1, wd, wa, da, nd, nw, bm, be);
            total++;
            if (wd !== ex[k] || da !== 33) begin
                bad++; $display("FAIL mulh_f%0d: got wd=%h done_at=%0d need %h/33", fs[k], wd, da, ex[k]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  fs [3] = '{3'b100, 3'b110, 3'b101};
        logic [31:0] as [3] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] ex [3] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC};
        logic [31:0] wd; logic [4:0] wa; int da, nd, nw; logic bm, be;
        for (int k = 0; k < 3; k++) begin
            do_op(fs[k], as[k], 32'd2, 5'd9, -1, wd, wa, da, nd, nw, bm, be);
            total++;
            if (wd !== ex[k] || da !== 33) begin
                bad++; $display("FAIL div_f%0d: got wd=%h done_at=%0d need %h/33", fs[k], wd, da, ex[k]);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  fs [5] = '{3'b100, 3'b111, 3'b100, 3'b110, 3'b101};
        logic [31:0] as [5] = '{32'd42, 32'd42, 32'h80000000, 32'h80000000, 32'h80000000};
        logic [31:0] bs [5] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] ex [5] = '{32'hFFFFFFFF, 32'd42, 32'h80000000, 32'd0, 32'd0};
        logic [31:0] wd; logic [4:0] wa; int da, nd, nw; logic bm, be;
        for (int k = 0; k < 5; k++) begin
            do_op(fs[k], as[k], bs[k], 5'd3, -1, wd, wa, da, nd, nw, bm, be);
            total++;
            if (wd !== ex[k] || da !== 33 || be !== 1'b0) begin
                bad++; $display("FAIL special_%0d: got wd=%h done_at=%0d busy@E34=%b need %h/33/0",
                                k, wd, da, be, ex[k]);
            end
        end
    endtask

    task automatic test_busy_start();
        logic [31:0] wd; logic [4:0] wa; int da, nd, nw; logic bm, be;
        do_op(3'b101, 32'd100, 32'd7, 5'd12, 10, wd, wa, da, nd, nw, bm, be);
        total++;
        if (nd !== 1 || wa !== 5'd12 || wd !== 32'd14 || da !== 33) begin
            bad++; $display("FAIL busy_start: n_done=%0d wa=%0d wd=%h done_at=%0d need 1/12/0000000e/33",
                            nd, wa, wd, da);
        end
        repeat (40) begin
            @(posedge w_clk); #1;
            if (w_done) nd++;
        end
        total++;
        if (nd !== 1) begin bad++; $display("FAIL busy_start_queue: n_done=%0d need 1", nd); end
    endtask

    task automatic test_rd_zero();
        logic [31:0] wd; logic [4:0] wa; int da, nd, nw; logic bm, be;
        do_op(3'b000, 32'd6, 32'd7, 5'd0, -1, wd, wa, da, nd, nw, bm, be);
        total++;
        if (nd !== 1 || nw !== 0 || wd !== 32'd42 || da !== 33) begin
            bad++; $display("FAIL rd_zero: n_done=%0d n_we=%0d wd=%h done_at=%0d need 1/0/0000002a/33",
                            nd, nw, wd, da);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] wd; logic [4:0] wa; int da, nd, nw; logic bm, be;
        int n_act;
        w_funct3 = 3'b000; w_rs1 = 32'd3; w_rs2 = 32'd5; w_rd = 5'd4; w_start = 1'b1;
        @(posedge w_clk); #1;
        w_start = 1'b0;
        repeat (19) @(posedge w_clk);
        #1;
        w_rst_n = 1'b0;
        @(posedge w_clk); #1;
        total++;
        if ({w_busy, w_done, w_we, w_wa, w_wd} !== 40'd0) begin
            bad++; $display("FAIL abort_state: busy=%b done=%b we=%b wa=%0d wd=%h need all 0",
                            w_busy, w_done, w_we, w_wa, w_wd);
        end
        w_rst_n = 1'b1;
        n_act = 0;
        repeat (40) begin
            @(posedge w_clk); #1;
            if (w_we || w_done || w_busy) n_act++;
        end
        total++;
        if (n_act !== 0) begin bad++; $display("FAIL abort_quiet: active cycles=%0d need 0", n_act); end
        do_op(3'b000, 32'd3, 32'd5, 5'd4, -1, wd, wa, da, nd, nw, bm, be);
        total++;
        if (wd !== 32'd15 || wa !== 5'd4 || nw !== 1 || da !== 33) begin
            bad++; $display("FAIL abort_restart: wd=%h wa=%0d n_we=%0d done_at=%0d need 0000000f/4/1/33",
                            wd, wa, nw, da);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wd1, wd2; logic [4:0] wa1, wa2; int da1, da2, nd, nw; logic bm, be;
        do_op(3'b101, 32'd1000, 32'd10, 5'd1, -1, wd1, wa1, da1, nd, nw, bm, be);
        do_op(3'b111, 32'd1003, 32'd10, 5'd2, -1, wd2, wa2, da2, nd, nw, bm, be);
        total++;
        if (wd1 !== 32'd100 || wa1 !== 5'd1 || da1 !== 33 || wd2 !== 32'd3 || wa2 !== 5'd2 || da2 !== 33) begin
            bad++; $display("FAIL back_to_back: got %h/%0d/%0d %h/%0d/%0d need 00000064/1/33 00000003/2/33",
                            wd1, wa1, da1, wd2, wa2, da2);
        end
    endtask

    task automatic test_random();
        logic [31:0] wd; logic [4:0] wa; int da, nd, nw; logic bm, be;
        logic [31:0] pool [4] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] a, b, exp_wd;
        logic [2:0]  f;
        for (int n = 0; n < 1000; n++) begin
            f = 3'(n % 8);
            a = ($urandom_range(0, 7) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            b = ($urandom_range(0, 7) == 0) ? pool[$urandom_range(0, 3)] : $urandom;
            if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
            exp_wd = ref_op(f, a, b);
            do_op(f, a, b, 5'd17, -1, wd, wa, da, nd, nw, bm, be);
            total++;
            if (wd !== exp_wd || da !== 33 || nd !== 1 || nw !== 1 || be !== 1'b0) begin
                bad++; $display("FAIL random_%0d: f=%0d a=%h b=%h got wd=%h done_at=%0d need %h/33",
                                n, f, a, b, wd, da, exp_wd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_special();
        test_busy_start();
        test_rd_zero();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
